merge_fill_arbiter: RTL

- Parametrised, sequential fill-request arbiter between NUM_UNITS merge units and one page-buffer fill port.
- Generalises the fixed per-segment fill-request interface to any unit count.
- Adds two arbitration modes: round-robin, and urgency by empty-bin count with a starvation guard.
- Tracks per-unit outstanding fills, presents a registered valid/ready output, and flags protocol errors.

---
 rtl/merge_arb_pkg.sv | 24 ++
 rtl/rr_priority_pick.sv | 32 +++
 rtl/merge_fill_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/merge_arb_pkg.sv
// Shared types and helpers for the merge-unit fill arbiter.
// Mode encodings, unit index type and empty-bin popcount.
package merge_arb_pkg;

  localparam logic MODE_RR     = 1'b0;
  localparam logic MODE_URGENT = 1'b1;

  // Widest empty-flag vector the popcount helper supports.
  localparam int MAX_BINS = 32;

  typedef logic [7:0] unit_idx_t;
  typedef logic [$clog2(MAX_BINS+1)-1:0] pop_t;

  // Counts empty bins; callers zero-extend their flag vector.
  function automatic pop_t popcount(input logic [MAX_BINS-1:0] v);
    pop_t c;
    c = '0;
    for (int i = 0; i < MAX_BINS; i++) begin
      c = c + pop_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set mask bit at or after start.
// Produces one-hot grant, its index and an any-request flag.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] pos;

  // Walk the mask from start, wrapping, and keep the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(start) + k) % N);
      if (!any && mask[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/merge_fill_arbiter.sv
// Fill-request arbiter between merge units and one page-buffer port.
// Round-robin or urgency (empty-bin count) with a starvation guard.
module merge_fill_arbiter
  import merge_arb_pkg::*;
#(
  parameter int NUM_UNITS       = 4,
  parameter int ADDR_W          = 8,
  parameter int NUM_BINS        = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 8,
  localparam int UW = $clog2(NUM_UNITS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 mode,
  input  logic [NUM_UNITS-1:0]                 req_valid,
  input  logic [NUM_UNITS-1:0][ADDR_W-1:0]     req_addr,
  input  logic [NUM_UNITS-1:0][NUM_BINS-1:0]   bin_empty_flags,
  output logic [NUM_UNITS-1:0]                 req_accepted,
  output logic                                 fill_valid,
  output logic [ADDR_W-1:0]                    fill_addr,
  output logic [UW-1:0]                        fill_unit,
  input  logic                                 fill_ready,
  input  logic                                 fill_done,
  input  logic [UW-1:0]                        fill_done_unit,
  output logic                                 busy,
  output logic                                 err
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int AGW = $clog2(STARVE_LIMIT + 1);
  localparam logic [OW-1:0]  OUT_MAX = OW'(MAX_OUTSTANDING);
  localparam logic [AGW-1:0] AGE_MAX = AGW'(STARVE_LIMIT);

  logic [NUM_UNITS-1:0][OW-1:0]  outstanding;
  logic [NUM_UNITS-1:0][AGW-1:0] age;
  logic [UW-1:0]                 ptr;
  logic [NUM_UNITS-1:0]          pend;

  logic [NUM_UNITS-1:0] elig;
  logic [NUM_UNITS-1:0] tie_mask;
  logic [NUM_UNITS-1:0] starve_mask;
  logic [NUM_UNITS-1:0] dec_ok;
  logic [MAX_BINS-1:0]  flags_ext;
  pop_t                 pop [NUM_UNITS];
  pop_t                 max_pop;

  logic [NUM_UNITS-1:0] rr_gnt, tie_gnt, stv_gnt, win_gnt;
  logic [UW-1:0]        rr_idx, tie_idx, stv_idx, win_idx;
  logic                 rr_any, tie_any, stv_any;
  logic                 slot;
  logic                 grant_any;
  logic                 bad_done;

  // Empty-bin count per unit, used only by urgency mode.
  always_comb begin
    flags_ext = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      flags_ext = '0;
      flags_ext[NUM_BINS-1:0] = bin_empty_flags[u];
      pop[u] = popcount(flags_ext);
    end
  end

  // Eligibility, max-urgency tie set and starved set.
  always_comb begin
    elig        = '0;
    tie_mask    = '0;
    starve_mask = '0;
    max_pop     = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      elig[u] = req_valid[u] && (outstanding[u] < OUT_MAX);
      starve_mask[u] = elig[u] && (mode == MODE_URGENT)
                     && (age[u] == AGE_MAX);
    end
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (elig[u] && (pop[u] > max_pop)) max_pop = pop[u];
    end
    for (int u = 0; u < NUM_UNITS; u++) begin
      tie_mask[u] = elig[u] && (pop[u] == max_pop);
    end
  end

  rr_priority_pick #(.N(NUM_UNITS), .IW(UW)) u_rr_pick (
    .mask  (elig),
    .start (ptr),
    .grant (rr_gnt),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  rr_priority_pick #(.N(NUM_UNITS), .IW(UW)) u_tie_pick (
    .mask  (tie_mask),
    .start (ptr),
    .grant (tie_gnt),
    .idx   (tie_idx),
    .any   (tie_any)
  );

  rr_priority_pick #(.N(NUM_UNITS), .IW(UW)) u_stv_pick (
    .mask  (starve_mask),
    .start (ptr),
    .grant (stv_gnt),
    .idx   (stv_idx),
    .any   (stv_any)
  );

  // Winner select and grant pulse; starved units beat urgency.
  always_comb begin
    win_gnt = rr_gnt;
    win_idx = rr_idx;
    if (mode == MODE_URGENT) begin
      if (stv_any) begin
        win_gnt = stv_gnt;
        win_idx = stv_idx;
      end else if (tie_any) begin
        win_gnt = tie_gnt;
        win_idx = tie_idx;
      end
    end
    slot         = enable && (!fill_valid || fill_ready);
    grant_any    = slot && rr_any && !rst;
    req_accepted = grant_any ? win_gnt : '0;
  end

  // Completion decode; a done for an idle or unknown unit is an error.
  always_comb begin
    dec_ok = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      dec_ok[u] = fill_done && (fill_done_unit == UW'(u))
                && (outstanding[u] != '0);
    end
    bad_done = fill_done && !(|dec_ok);
  end

  assign busy = fill_valid || (|outstanding);

  // Registered output request and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_unit  <= '0;
      ptr        <= '0;
    end else if (grant_any) begin
      fill_valid <= 1'b1;
      fill_addr  <= req_addr[win_idx];
      fill_unit  <= win_idx;
      ptr <= (win_idx == UW'(NUM_UNITS - 1)) ? '0 : win_idx + 1'b1;
    end else if (fill_ready) begin
      fill_valid <= 1'b0;
    end
  end

  // Per-unit fills in flight; grant and done together cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        unique case ({req_accepted[u], dec_ok[u]})
          2'b10:   outstanding[u] <= outstanding[u] + 1'b1;
          2'b01:   outstanding[u] <= outstanding[u] - 1'b1;
          default: outstanding[u] <= outstanding[u];
        endcase
      end
    end
  end

  // Bypass age per unit; only meaningful in urgency mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= '0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if ((mode != MODE_URGENT) || !elig[u] || req_accepted[u]) begin
          age[u] <= '0;
        end else if (grant_any && (age[u] != AGE_MAX)) begin
          age[u] <= age[u] + 1'b1;
        end
      end
    end
  end

  // Sticky protocol error: bad done, or a request withdrawn unserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      err  <= 1'b0;
    end else begin
      pend <= req_valid & ~req_accepted;
      err  <= err | bad_done | (|(pend & ~req_valid));
    end
  end

endmodule
